frame_src_ctrl: RTL and testbench
=================================

# frame_src_ctrl

Frame-source controller between the pixel producers (camera capture path and the UART RX pixel assembler) and the frame buffer write port. It selects one source per frame, and source changes take effect only at frame boundaries. It generates linear frame-buffer write addresses and holds each completed frame behind a ready/ack handshake until the downstream image-processing stage releases it.

## Interface
- DATA_WIDTH, 8, bits per colour channel
- IMG_WIDTH, 170, pixels per line
- IMG_HEIGHT, 240, lines per frame
- TOTAL_PIXELS, IMG_WIDTH*IMG_HEIGHT, pixels per frame
- ADDR_WIDTH, $clog2(TOTAL_PIXELS), frame-buffer address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mode_req  in  1  requested source: 1 = camera, 0 = UART; sampled only in IDLE
- cam_vsync  in  1  one-cycle camera frame-start pulse
- cam_valid  in  1  camera pixel strobe
- cam_rgb  in  3*DATA_WIDTH  camera pixel
- uart_pixel_done  in  1  UART assembler pixel strobe
- uart_rgb  in  3*DATA_WIDTH  UART assembled pixel
- uart_frame_done  in  1  UART assembler end-of-frame pulse
- frame_ack  in  1  downstream has consumed the frame
- cam_mode  out  1  registered active source; feeds the UART assembler's cam_mode
- fb_we  out  1  frame-buffer write enable
- fb_addr  out  ADDR_WIDTH  write address
- fb_wdata  out  3*DATA_WIDTH  write data
- frame_ready  out  1  complete frame held in buffer
- busy  out  1  high in CAM_WAIT, CAM_FRAME and UART_FRAME
- short_frame  out  1  one-cycle pulse: camera frame aborted early
- overrun  out  1  sticky: pixel dropped while frame held; cleared on frame_ack

## Operation
- States: IDLE, CAM_WAIT, CAM_FRAME, UART_FRAME, HOLD.
- IDLE:
  - latch mode_req into cam_mode.
  - mode_req=1 → CAM_WAIT.
  - mode_req=0 → UART_FRAME.
  - Clear pixel count to 0.
- CAM_WAIT:
  - cam_valid ignored.
  - cam_vsync → CAM_FRAME, count = 0.
- CAM_FRAME:
  - Each cam_valid writes cam_rgb at address = count, then count++.
  - The write with count = TOTAL_PIXELS-1 → HOLD.
  - cam_vsync while count ≠ 0 → pulse short_frame, count = 0, stay in CAM_FRAME.
  - cam_vsync in the same cycle as cam_valid: the vsync reset is applied first, and the pixel is written at address 0 with count → 1.
- UART_FRAME:
  - Each uart_pixel_done writes uart_rgb at address = count, then count++.
  - → HOLD on the write with count = TOTAL_PIXELS-1, or on uart_frame_done, whichever comes first.
  - uart_frame_done coincident with a pixel: the pixel is written first, then → HOLD.
  - Count saturates at TOTAL_PIXELS-1; no wrap.
- HOLD:
  - frame_ready = 1.
  - Strobes from the active source are dropped and set overrun.
  - frame_ack → IDLE and clears overrun.
  - A strobe in the same cycle as frame_ack is dropped and does not set overrun.
- Strobes from the inactive source are ignored in all states.
- mode_req changes outside IDLE have no effect until the next IDLE.
- frame_ack outside HOLD is ignored.

## Timing
- Reset values:
  - state = IDLE
  - cam_mode = 0
  - fb_we = 0
  - fb_addr = 0
  - fb_wdata = 0
  - frame_ready = 0
  - busy = 0
  - short_frame = 0
  - overrun = 0
- All outputs are registered.
- fb_we, fb_addr and fb_wdata are valid exactly 1 cycle after the accepted strobe.
- fb_we is high for exactly 1 cycle per accepted pixel.
- frame_ready rises in the same cycle as the final fb_we, and falls 1 cycle after frame_ack.
- IDLE lasts exactly 1 cycle; UART back-to-back frames incur one dead cycle.
- Reset mid-frame: immediate return to IDLE and all outputs go to their reset values; the partial frame is abandoned.

## Structure
- Package frame_src_pkg holds:
  - state_t enum (IDLE, CAM_WAIT, CAM_FRAME, UART_FRAME, HOLD).
  - src_t enum (SRC_UART=0, SRC_CAM=1).
  - Default image dimension constants.
- One sub-module, frame_addr_counter: parameterised over ADDR_WIDTH/TOTAL_PIXELS, with clear, increment, saturate and a last-pixel flag.
- Everything else stays in a single FSM module.

## Test plan
- UART frame, TOTAL_PIXELS=12 (4×3):
  - mode_req=0, 12 uart_pixel_done strobes → 12 fb_we with addresses 0..11 and data matching.
  - frame_ready rises with address 11; busy=0.
- Camera frame:
  - mode_req=1; 5 cam_valid strobes before vsync → no fb_we.
  - Then vsync + 12 strobes → addresses 0..11, frame_ready=1.
- Short camera frame: 7 pixels, then cam_vsync → short_frame pulse, next pixel written at address 0, frame completes after 12 more pixels.
- Early UART end: uart_frame_done after 5 pixels → HOLD with the last address at 4.
- Overrun: 3 strobes in HOLD → overrun=1 and no fb_we; frame_ack → overrun=0, state IDLE, frame_ready low the next cycle.
- Reset and mode sampling:
  - Assert reset mid-UART frame at address 6 → all outputs zero asynchronously; after release, a new frame starts at address 0.
  - Toggle mode_req during UART_FRAME → cam_mode unchanged until IDLE.

Source files
------------

// File: rtl/frame_src_pkg.sv
// Shared types and default image geometry for the frame-source controller.
package frame_src_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAM_WAIT,
    CAM_FRAME,
    UART_FRAME,
    HOLD
  } state_t;

  typedef enum logic {
    SRC_UART = 1'b0,
    SRC_CAM  = 1'b1
  } src_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_WIDTH  = 170;
  localparam int DEF_IMG_HEIGHT = 240;

endpackage

// File: rtl/frame_addr_counter.sv
// Linear frame-buffer address counter: clear, increment, saturate at the last pixel.
module frame_addr_counter #(
  parameter int TOTAL_PIXELS = 40800,
  parameter int ADDR_WIDTH   = $clog2(TOTAL_PIXELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] AFTER_CLR = (TOTAL_PIXELS > 1) ? ADDR_WIDTH'(1) : '0;

  assign last = (count == LAST_ADDR);

  // clear+inc together means the pixel lands at address 0, so the next address is 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? AFTER_CLR : '0;
    end else if (inc && !last) begin
      count <= count + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/frame_src_ctrl.sv
// Selects camera or UART as the frame source per frame, writes pixels linearly
// into the frame buffer and holds each finished frame until downstream acks it.
module frame_src_ctrl
  import frame_src_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
  parameter int ADDR_WIDTH   = $clog2(TOTAL_PIXELS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode_req,
  input  logic                    cam_vsync,
  input  logic                    cam_valid,
  input  logic [3*DATA_WIDTH-1:0] cam_rgb,
  input  logic                    uart_pixel_done,
  input  logic [3*DATA_WIDTH-1:0] uart_rgb,
  input  logic                    uart_frame_done,
  input  logic                    frame_ack,
  output logic                    cam_mode,
  output logic                    fb_we,
  output logic [ADDR_WIDTH-1:0]   fb_addr,
  output logic [3*DATA_WIDTH-1:0] fb_wdata,
  output logic                    frame_ready,
  output logic                    busy,
  output logic                    short_frame,
  output logic                    overrun
);

  state_t                  state, next_state;
  src_t                    src_q;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    cnt_last, cnt_clear, cnt_inc;
  logic                    wr_en, short_hit, ovr_set, ovr_clr, active_strobe;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [3*DATA_WIDTH-1:0] wr_data;

  frame_addr_counter #(
    .TOTAL_PIXELS(TOTAL_PIXELS),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clear),
    .inc  (cnt_inc),
    .count(cnt),
    .last (cnt_last)
  );

  assign cam_mode      = (src_q == SRC_CAM);
  assign active_strobe = cam_mode ? cam_valid : uart_pixel_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = cnt;
    wr_data    = '0;
    short_hit  = 1'b0;
    ovr_set    = 1'b0;
    ovr_clr    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clear  = 1'b1;
        next_state = mode_req ? CAM_WAIT : UART_FRAME;
      end
      CAM_WAIT: begin
        if (cam_vsync) begin
          cnt_clear  = 1'b1;
          next_state = CAM_FRAME;
        end
      end
      CAM_FRAME: begin
        if (cam_vsync) begin
          cnt_clear = 1'b1;
          short_hit = (cnt != '0);
        end
        // a pixel coincident with vsync belongs to the new frame
        if (cam_valid) begin
          wr_en   = 1'b1;
          cnt_inc = 1'b1;
          wr_data = cam_rgb;
          wr_addr = cam_vsync ? '0 : cnt;
          if (!cam_vsync && cnt_last) next_state = HOLD;
        end
      end
      UART_FRAME: begin
        if (uart_pixel_done) begin
          wr_en   = 1'b1;
          cnt_inc = 1'b1;
          wr_data = uart_rgb;
          if (cnt_last) next_state = HOLD;
        end
        if (uart_frame_done) next_state = HOLD;
      end
      HOLD: begin
        if (frame_ack) begin
          next_state = IDLE;
          ovr_clr    = 1'b1;
        end else if (active_strobe) begin
          ovr_set = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // outputs are registered from the decoded next state so they line up with the write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q       <= SRC_UART;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_wdata    <= '0;
      frame_ready <= 1'b0;
      busy        <= 1'b0;
      short_frame <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (state == IDLE) src_q <= src_t'(mode_req);
      fb_we <= wr_en;
      if (wr_en) begin
        fb_addr  <= wr_addr;
        fb_wdata <= wr_data;
      end
      frame_ready <= (next_state == HOLD);
      busy        <= (next_state == CAM_WAIT) || (next_state == CAM_FRAME) ||
                     (next_state == UART_FRAME);
      short_frame <= short_hit;
      if (ovr_clr)      overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_src_ctrl.sv
// Directed bench for frame_src_ctrl on a 4x3 image (12 pixels per frame).
module tb_frame_src_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mode_req = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_valid = 1'b0;
  logic [3*DW-1:0] cam_rgb = '0;
  logic          uart_pixel_done = 1'b0;
  logic [3*DW-1:0] uart_rgb = '0;
  logic          uart_frame_done = 1'b0;
  logic          frame_ack = 1'b0;
  logic          cam_mode, fb_we, frame_ready, busy, short_frame, overrun;
  logic [AW-1:0] fb_addr;
  logic [3*DW-1:0] fb_wdata;

  int total = 0;
  int bad = 0;

  frame_src_ctrl #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mode_req       (mode_req),
    .cam_vsync      (cam_vsync),
    .cam_valid      (cam_valid),
    .cam_rgb        (cam_rgb),
    .uart_pixel_done(uart_pixel_done),
    .uart_rgb       (uart_rgb),
    .uart_frame_done(uart_frame_done),
    .frame_ack      (frame_ack),
    .cam_mode       (cam_mode),
    .fb_we          (fb_we),
    .fb_addr        (fb_addr),
    .fb_wdata       (fb_wdata),
    .frame_ready    (frame_ready),
    .busy           (busy),
    .short_frame    (short_frame),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3*DW-1:0] px(input int a, input int salt);
    return {8'(a + salt), 8'(a * 7), 8'(8'hF0 ^ 8'(a))};
  endfunction

  task automatic uart_px(input int a, input int salt, input logic done, input logic rdy);
    logic [3*DW-1:0] d;
    d = px(a, salt);
    uart_rgb = d;
    uart_pixel_done = 1'b1;
    uart_frame_done = done;
    tick();
    uart_pixel_done = 1'b0;
    uart_frame_done = 1'b0;
    chk("uart_we", 32'(fb_we), 1);
    chk("uart_addr", 32'(fb_addr), 32'(a));
    chk("uart_data", 32'(fb_wdata), 32'(d));
    chk("uart_ready", 32'(frame_ready), 32'(rdy));
  endtask

  task automatic cam_px(input int a, input int salt, input logic vs, input logic shrt,
                        input logic rdy);
    logic [3*DW-1:0] d;
    d = px(a, salt);
    cam_rgb = d;
    cam_valid = 1'b1;
    cam_vsync = vs;
    tick();
    cam_valid = 1'b0;
    cam_vsync = 1'b0;
    chk("cam_we", 32'(fb_we), 1);
    chk("cam_addr", 32'(fb_addr), 32'(a));
    chk("cam_data", 32'(fb_wdata), 32'(d));
    chk("cam_short", 32'(short_frame), 32'(shrt));
    chk("cam_ready", 32'(frame_ready), 32'(rdy));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cam_mode"}, 32'(cam_mode), 0);
    chk({tag, "_we"}, 32'(fb_we), 0);
    chk({tag, "_addr"}, 32'(fb_addr), 0);
    chk({tag, "_wdata"}, 32'(fb_wdata), 0);
    chk({tag, "_ready"}, 32'(frame_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_short"}, 32'(short_frame), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    // reset state
    #2;
    chk_reset_outs("rst");
    tick();
    tick();
    reset = 1'b1;
    chk_reset_outs("rst_rel");

    // full UART frame
    tick();
    chk("uart_busy_start", 32'(busy), 1);
    chk("uart_cam_mode", 32'(cam_mode), 0);
    for (int i = 0; i < 12; i++) begin
      uart_px(i, 16, 1'b0, (i == 11));
      chk("uart_busy", 32'(busy), 32'(i != 11));
    end
    tick();
    chk("we_one_cycle", 32'(fb_we), 0);
    chk("hold_ready", 32'(frame_ready), 1);

    // inactive source in HOLD is ignored, active strobes set overrun
    cam_valid = 1'b1;
    tick();
    cam_valid = 1'b0;
    chk("inactive_no_ovr", 32'(overrun), 0);
    for (int i = 0; i < 3; i++) begin
      uart_pixel_done = 1'b1;
      tick();
      uart_pixel_done = 1'b0;
      chk("ovr_no_we", 32'(fb_we), 0);
      chk("ovr_set", 32'(overrun), 1);
    end
    frame_ack = 1'b1;
    uart_pixel_done = 1'b1;
    mode_req = 1'b1;
    tick();
    frame_ack = 1'b0;
    uart_pixel_done = 1'b0;
    chk("ack_ovr_clr", 32'(overrun), 0);
    chk("ack_ready_low", 32'(frame_ready), 0);
    chk("ack_no_we", 32'(fb_we), 0);
    chk("idle_busy", 32'(busy), 0);

    // camera frame: pixels before vsync are ignored
    tick();
    chk("cam_mode_set", 32'(cam_mode), 1);
    chk("cam_wait_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      cam_valid = 1'b1;
      tick();
      cam_valid = 1'b0;
      chk("cam_wait_no_we", 32'(fb_we), 0);
    end
    cam_vsync = 1'b1;
    tick();
    cam_vsync = 1'b0;
    chk("vsync_no_we", 32'(fb_we), 0);
    chk("vsync_first_no_short", 32'(short_frame), 0);
    for (int i = 0; i < 12; i++) cam_px(i, 32, 1'b0, 1'b0, (i == 11));
    chk("cam_hold_busy", 32'(busy), 0);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    tick();
    cam_vsync = 1'b1;
    tick();
    cam_vsync = 1'b0;

    // short camera frame, then vsync coincident with a pixel
    for (int i = 0; i < 7; i++) cam_px(i, 48, 1'b0, 1'b0, 1'b0);
    cam_vsync = 1'b1;
    tick();
    cam_vsync = 1'b0;
    chk("short_pulse", 32'(short_frame), 1);
    chk("short_no_we", 32'(fb_we), 0);
    for (int i = 0; i < 3; i++) cam_px(i, 64, 1'b0, 1'b0, 1'b0);
    cam_px(0, 80, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 12; i++) cam_px(i, 80, 1'b0, 1'b0, (i == 11));

    // early UART end; mode_req toggled mid-frame has no effect
    mode_req = 1'b0;
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    tick();
    chk("uart2_cam_mode", 32'(cam_mode), 0);
    mode_req = 1'b1;
    for (int i = 0; i < 4; i++) uart_px(i, 96, 1'b0, 1'b0);
    chk("mode_toggle_ignored", 32'(cam_mode), 0);
    uart_px(4, 96, 1'b1, 1'b1);
    chk("early_end_busy", 32'(busy), 0);
    tick();
    chk("early_end_we_low", 32'(fb_we), 0);
    chk("early_end_hold", 32'(frame_ready), 1);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("idle_cam_mode_old", 32'(cam_mode), 0);
    tick();
    chk("idle_cam_mode_new", 32'(cam_mode), 1);

    // asynchronous reset from CAM_WAIT, then mid-UART-frame
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("areset_cam");
    mode_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) uart_px(i, 112, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("areset_uart");
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_busy", 32'(busy), 1);
    uart_px(0, 128, 1'b0, 1'b0);
    uart_px(1, 128, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
